// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampling UART receiver with receive FIFO and sticky errors; break detect under UART_RX_BREAK_DETECT_EN
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  input  logic                          err_clr,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun_err,
  output logic                          break_det
);

  localparam int DIV   = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int HALF  = OVERSAMPLE / 2;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d, sync2_q, sync2_d, rx_prev_q, rx_prev_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [OS_W-1:0]   samp_q, samp_d;
  logic [1:0]        vote_q, vote_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_pend_q, par_pend_d;
  logic              brk_wait_q, brk_wait_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              frame_err_q, frame_err_d, parity_err_q, parity_err_d;
  logic              overrun_err_q, overrun_err_d, break_det_q, break_det_d;
  logic [7:0]        mem_q [FIFO_DEPTH];

  logic tick, fall, samp_end, decide, voted, par_exp;
  logic push_req, push, pop, full;
  logic frame_set, par_set, ovr_set, brk_set;

  // Next-state logic: synchroniser, tick divider, receive FSM, FIFO pointers and sticky flags
  always_comb begin
    sync1_d    = rx;
    sync2_d    = sync1_q;
    rx_prev_d  = sync2_q;
    tick       = (div_q == DIV_W'(DIV - 1));
    div_d      = tick ? '0 : div_q + 1'b1;
    fall       = rx_prev_q & ~sync2_q;
    samp_end   = tick && (samp_q == OS_W'(OVERSAMPLE - 1));
    decide     = tick && (samp_q == OS_W'(HALF + 1));
    voted      = (vote_q[0] & vote_q[1]) | (vote_q[0] & sync2_q) | (vote_q[1] & sync2_q);
    par_exp    = (PARITY == 1) ? ~(^shift_q) : ^shift_q;
    state_d    = state_q;
    samp_d     = samp_q;
    vote_d     = vote_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_pend_d = par_pend_q;
    brk_wait_d = brk_wait_q;
    push_req   = 1'b0;
    frame_set  = 1'b0;
    par_set    = 1'b0;
    brk_set    = 1'b0;

    // Sample counter runs on ticks; first two vote samples are captured before the decision point
    if (tick) begin
      samp_d = samp_end ? '0 : samp_q + 1'b1;
      if (samp_q == OS_W'(HALF - 1)) vote_d[0] = sync2_q;
      if (samp_q == OS_W'(HALF))     vote_d[1] = sync2_q;
    end

    case (state_q)
      S_IDLE: begin
        if (brk_wait_q) begin
          // After a break the line must stay high for a whole bit before a new start is accepted
          if (!sync2_q)      samp_d     = '0;
          else if (samp_end) brk_wait_d = 1'b0;
        end else if (fall) begin
          state_d    = S_START;
          samp_d     = '0;
          bit_d      = '0;
          shift_d    = '0;
          par_pend_d = 1'b0;
        end
      end
      S_START: begin
        if (decide && voted) state_d = S_IDLE;
        else if (samp_end)   state_d = S_DATA;
      end
      S_DATA: begin
        if (decide) shift_d = (shift_q >> 1) | (8'(voted) << (DATA_BITS - 1));
        if (samp_end) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'(DATA_BITS - 1)) state_d = (PARITY != 0) ? S_PAR : S_STOP;
        end
      end
      S_PAR: begin
        if (decide && (voted != par_exp)) par_pend_d = 1'b1;
        if (samp_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (decide) begin
          state_d   = S_IDLE;
          frame_set = ~voted;
          par_set   = par_pend_q;
`ifdef UART_RX_BREAK_DETECT_EN
          if ((shift_q == 8'h00) && !voted) begin
            brk_set    = 1'b1;
            brk_wait_d = 1'b1;
            samp_d     = '0;
          end else begin
            push_req = 1'b1;
          end
`else
          push_req = 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    full     = (count_q == CW'(FIFO_DEPTH));
    pop      = rd_en && (count_q != '0);
    push     = push_req && (!full || pop);
    ovr_set  = push_req && full && !pop;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    frame_err_d   = (frame_err_q   & ~err_clr) | frame_set;
    parity_err_d  = (parity_err_q  & ~err_clr) | par_set;
    overrun_err_d = (overrun_err_q & ~err_clr) | ovr_set;
    break_det_d   = (break_det_q   & ~err_clr) | brk_set;
  end

  // State register; reset aborts any frame in progress and empties the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      rx_prev_q     <= 1'b1;
      div_q         <= '0;
      samp_q        <= '0;
      vote_q        <= 2'b11;
      bit_q         <= '0;
      shift_q       <= '0;
      par_pend_q    <= 1'b0;
      brk_wait_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
      break_det_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      rx_prev_q     <= rx_prev_d;
      div_q         <= div_d;
      samp_q        <= samp_d;
      vote_q        <= vote_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      par_pend_q    <= par_pend_d;
      brk_wait_q    <= brk_wait_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      frame_err_q   <= frame_err_d;
      parity_err_q  <= parity_err_d;
      overrun_err_q <= overrun_err_d;
      break_det_q   <= break_det_d;
    end
  end

  // FIFO storage; validity is tracked by the pointers so the array needs no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rd_valid    = (count_q != '0);
  assign rd_data     = rd_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count  = count_q;
  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overrun_err = overrun_err_q;
  assign break_det   = break_det_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  localparam int CLK_FREQ = 7_372_800;
  localparam int BIT      = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic rd_en_a = 1'b0, rd_en_b = 1'b0, rd_en_c = 1'b0;
  logic clr_a = 1'b0, clr_b = 1'b0, clr_c = 1'b0;
  logic [7:0] rd_data_a, rd_data_b, rd_data_c;
  logic rd_valid_a, rd_valid_b, rd_valid_c;
  logic [4:0] count_a, count_b;
  logic [2:0] count_c;
  logic fe_a, pe_a, oe_a, bd_a;
  logic fe_b, pe_b, oe_b, bd_b;
  logic fe_c, pe_c, oe_c, bd_c;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] hello [13] = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h20, 8'h57,
                             8'h6f, 8'h72, 8'h6c, 8'h64, 8'h21, 8'h0a};

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  uart_rx_fifo #(.CLK_FREQ(CLK_FREQ)) u_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .rd_en(rd_en_a), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .fifo_count(count_a), .err_clr(clr_a), .frame_err(fe_a),
    .parity_err(pe_a), .overrun_err(oe_a), .break_det(bd_a));

  uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .DATA_BITS(7), .PARITY(2)) u_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .rd_en(rd_en_b), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .fifo_count(count_b), .err_clr(clr_b), .frame_err(fe_b),
    .parity_err(pe_b), .overrun_err(oe_b), .break_det(bd_b));

  uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst_n(rst_n), .rx(rx_c), .rd_en(rd_en_c), .rd_data(rd_data_c),
    .rd_valid(rd_valid_c), .fifo_count(count_c), .err_clr(clr_c), .frame_err(fe_c),
    .parity_err(pe_c), .overrun_err(oe_c), .break_det(bd_c));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_rx(input int which, input logic v);
    case (which)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic send_bit(input int which, input logic v);
    set_rx(which, v);
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input int nbits,
                            input logic has_par, input logic par_bit, input logic stop);
    send_bit(which, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(which, d[i]);
    if (has_par) send_bit(which, par_bit);
    send_bit(which, stop);
  endtask

  task automatic pop_check(input string tag, input int which, input logic [7:0] exp);
    case (which)
      0: begin check_val(tag, rd_data_a, exp); rd_en_a = 1'b1; @(negedge clk); rd_en_a = 1'b0; end
      1: begin check_val(tag, rd_data_b, exp); rd_en_b = 1'b1; @(negedge clk); rd_en_b = 1'b0; end
      default: begin check_val(tag, rd_data_c, exp); rd_en_c = 1'b1; @(negedge clk); rd_en_c = 1'b0; end
    endcase
  endtask

  task automatic pulse_clr(input int which);
    case (which)
      0:       clr_a = 1'b1;
      1:       clr_b = 1'b1;
      default: clr_c = 1'b1;
    endcase
    @(negedge clk);
    clr_a = 1'b0;
    clr_b = 1'b0;
    clr_c = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_val("reset_rd_data", rd_data_a, 8'h00);
    check_val("reset_rd_valid", rd_valid_a, 1'b0);
    check_val("reset_count", count_a, 0);
    check_val("reset_flags", {fe_a, pe_a, oe_a, bd_a}, 4'b0000);
    rst_n = 1'b1;
    repeat (BIT) @(negedge clk);

    // Back-to-back "Hello World!\n"
    for (int i = 0; i < 13; i++) send_frame(0, hello[i], 8, 1'b0, 1'b0, 1'b1);
    repeat (BIT) @(negedge clk);
    check_val("hello_count", count_a, 13);
    check_val("hello_flags", {fe_a, pe_a, oe_a, bd_a}, 4'b0000);
    for (int i = 0; i < 13; i++) pop_check($sformatf("hello_byte_%0d", i), 0, hello[i]);
    check_val("hello_empty_count", count_a, 0);
    check_val("hello_empty_valid", rd_valid_a, 1'b0);

    // Short low glitch on an idle line must be rejected
    rx_a = 1'b0;
    repeat (15) @(negedge clk);
    rx_a = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    check_val("glitch_count", count_a, 0);
    check_val("glitch_flags", {fe_a, pe_a, oe_a, bd_a}, 4'b0000);
    send_frame(0, 8'ha5, 8, 1'b0, 1'b0, 1'b1);
    repeat (BIT) @(negedge clk);
    check_val("post_glitch_count", count_a, 1);
    pop_check("post_glitch_byte", 0, 8'ha5);

    // Stop bit held low
    send_frame(0, 8'h55, 8, 1'b0, 1'b0, 1'b0);
    send_bit(0, 1'b1);
    check_val("frame_count", count_a, 1);
    check_val("frame_err", fe_a, 1'b1);
    check_val("frame_parity_clean", pe_a, 1'b0);
    pop_check("frame_byte", 0, 8'h55);
    pulse_clr(0);
    check_val("frame_err_cleared", fe_a, 1'b0);

`ifdef UART_RX_BREAK_DETECT_EN
    rx_a = 1'b0;
    repeat (20 * BIT) @(negedge clk);
    rx_a = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check_val("break_det", bd_a, 1'b1);
    check_val("break_frame_err", fe_a, 1'b1);
    check_val("break_count", count_a, 0);
    pulse_clr(0);
    check_val("break_cleared", bd_a, 1'b0);
`else
    send_frame(0, 8'h00, 8, 1'b0, 1'b0, 1'b0);
    send_bit(0, 1'b1);
    check_val("zero_frame_count", count_a, 1);
    check_val("zero_frame_err", fe_a, 1'b1);
    check_val("zero_break_det", bd_a, 1'b0);
    pop_check("zero_frame_byte", 0, 8'h00);
    pulse_clr(0);
`endif

    // Reset during data bit 3 with a byte queued and a flag set
    send_frame(0, 8'h11, 8, 1'b0, 1'b0, 1'b0);
    send_bit(0, 1'b1);
    check_val("pre_reset_count", count_a, 1);
    send_bit(0, 1'b0);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    set_rx(0, 1'b1);
    repeat (BIT / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_val("midreset_valid", rd_valid_a, 1'b0);
    check_val("midreset_count", count_a, 0);
    check_val("midreset_rd_data", rd_data_a, 8'h00);
    check_val("midreset_flags", {fe_a, pe_a, oe_a, bd_a}, 4'b0000);
    rst_n = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    send_frame(0, 8'h5a, 8, 1'b0, 1'b0, 1'b1);
    repeat (BIT) @(negedge clk);
    check_val("after_reset_count", count_a, 1);
    check_val("after_reset_frame_err", fe_a, 1'b0);
    pop_check("after_reset_byte", 0, 8'h5a);

    // 7 data bits, even parity: 0x41 has two ones, so the parity bit is 0
    send_frame(1, 8'h41, 7, 1'b1, 1'b0, 1'b1);
    repeat (BIT) @(negedge clk);
    check_val("par_good_count", count_b, 1);
    check_val("par_good_err", pe_b, 1'b0);
    send_frame(1, 8'h41, 7, 1'b1, 1'b1, 1'b1);
    repeat (BIT) @(negedge clk);
    check_val("par_bad_count", count_b, 2);
    check_val("par_bad_err", pe_b, 1'b1);
    check_val("par_bad_frame_err", fe_b, 1'b0);
    pop_check("par_byte_0", 1, 8'h41);
    pop_check("par_byte_1", 1, 8'h41);
    pulse_clr(1);
    check_val("par_err_cleared", pe_b, 1'b0);

    // Four-entry FIFO: overrun, then wrap and a pop on the full push edge
    for (int i = 1; i <= 5; i++) send_frame(2, 8'(i), 8, 1'b0, 1'b0, 1'b1);
    repeat (BIT) @(negedge clk);
    check_val("ovr_count", count_c, 4);
    check_val("ovr_err", oe_c, 1'b1);
    for (int i = 1; i <= 4; i++) pop_check($sformatf("ovr_byte_%0d", i), 2, 8'(i));
    check_val("ovr_drained", count_c, 0);
    pulse_clr(2);
    check_val("ovr_cleared", oe_c, 1'b0);

    // Align the frame start so the stop-bit push edge is 616 clocks after it
    for (int i = 0; i < 4 && (cyc % 4) != 0; i++) @(negedge clk);
    check_val("align_phase", cyc % 4, 0);
    for (int i = 6; i <= 9; i++) send_frame(2, 8'(i), 8, 1'b0, 1'b0, 1'b1);
    check_val("wrap_full_count", count_c, 4);
    fork
      send_frame(2, 8'h0a, 8, 1'b0, 1'b0, 1'b1);
      begin
        repeat (615) @(negedge clk);
        rd_en_c = 1'b1;
        @(negedge clk);
        rd_en_c = 1'b0;
      end
    join
    repeat (BIT) @(negedge clk);
    check_val("push_pop_full_count", count_c, 4);
    check_val("push_pop_full_no_ovr", oe_c, 1'b0);
    pop_check("wrap_byte_7", 2, 8'h07);
    pop_check("wrap_byte_8", 2, 8'h08);
    pop_check("wrap_byte_9", 2, 8'h09);
    pop_check("wrap_byte_a", 2, 8'h0a);
    check_val("wrap_empty", rd_valid_c, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with an integrated receive FIFO and sticky error flags, for the SoC peripheral bus side of the inverter controller. It is the synthesizable successor to the bench-only serial monitor: it oversamples and majority-votes the line and validates the start bit. Frame format (data bits, parity) is configurable, and received bytes are buffered so firmware can drain them at its own pace. It sits between the `uart_rx` pad and the UART register block.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 115200: line rate.
- `OVERSAMPLE`, 16: samples per bit. Must be ≥ 8 and even.
- `DATA_BITS`, 8: data bits per frame, 5..8.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `FIFO_DEPTH`, 16: receive FIFO entries. Must be a power of 2, ≥ 2.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `rx`, in, 1: serial input, asynchronous to `clk`, idle high.
- `rd_en`, in, 1: pop the FIFO head. Ignored when empty.
- `rd_data`, out, 8: FIFO head, zero-extended above `DATA_BITS`. First-word fall-through.
- `rd_valid`, out, 1: FIFO not empty.
- `fifo_count`, out, $clog2(FIFO_DEPTH)+1: current occupancy.
- `err_clr`, in, 1: clear all sticky error flags.
- `frame_err`, out, 1: sticky; stop bit sampled low.
- `parity_err`, out, 1: sticky; parity mismatch.
- `overrun_err`, out, 1: sticky; byte completed while FIFO full.
- `break_det`, out, 1: sticky; break detected. Tied 0 unless `UART_RX_BREAK_DETECT_EN` is defined.

## Operation
- **Synchroniser:** `rx` passes through a 2-flop synchroniser, reset to 1. All logic uses the synchronised value.
- **Tick divider:** `DIV = (CLK_FREQ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE)`, i.e. rounded. A counter produces one-cycle `tick` pulses every `DIV` clocks, free-running from reset.
- **Sampling:** a sample counter counts 0..OVERSAMPLE-1 on ticks.
  - Bit value is the majority of the samples at counts OVERSAMPLE/2-1, /2, /2+1.
  - The bit decision is made at count OVERSAMPLE/2+1.
- **FSM states:** IDLE, START, DATA, PAR, STOP.
  - IDLE → START on a synchronised falling edge. The sample counter is reset to 0.
  - START: if the voted start bit is 1, return to IDLE (glitch rejected, nothing recorded). Otherwise go to DATA at count OVERSAMPLE-1.
  - DATA: shift in LSB first. After `DATA_BITS` bits, go to PAR if `PARITY != 0`, else to STOP.
  - PAR: compare the received bit with the computed parity (odd/even over the data bits). On mismatch, set the pending parity flag.
  - STOP: on the voted stop bit, complete the frame and return to IDLE immediately at the decision point. Idle-high detection resumes; there is no wait for the bit end.
- **Frame completion:** the byte is pushed even with a frame or parity error. Errors set the corresponding sticky flags in the same cycle as the push attempt.
- **Overrun:** on completion with the FIFO full and no simultaneous pop, the byte is dropped and `overrun_err` is set. FIFO contents are unchanged.
- **FIFO push/pop:**
  - Simultaneous push and pop: both occur, and the count is unchanged, including when full.
  - Pop when empty: no effect.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Sticky flags:** if `err_clr` is asserted in the same cycle as a new error event, the set wins.
- **Reset:** reset mid-frame aborts the frame. The FSM returns to IDLE, the FIFO is emptied, and the partial byte is discarded.

## Timing
- **Reset values:**
  - `rd_data` = 0, `rd_valid` = 0, `fifo_count` = 0.
  - All error flags = 0.
  - FSM in IDLE, synchroniser = 1.
- **Input latency:** `rx` to internal edge detect is 2 clocks of synchronisation plus 1 clock of edge register.
- **Push latency:** the push is registered on the clock after the stop-bit decision. `rd_valid`, `rd_data` and `fifo_count` update on that same edge.
- **Pop:** `rd_en` with `rd_valid` high advances the head, and the new `rd_data` is visible on the next cycle.
- **Flags:** each sticky flag rises on the same edge as the push attempt that caused it. `err_clr` clears a flag on the next edge.

## Configuration
- **`UART_RX_BREAK_DETECT_EN`**, when defined:
  - A frame whose data bits and stop bit are all 0 is treated as a break.
  - It sets `break_det` and `frame_err` but is NOT pushed to the FIFO.
  - The FSM then waits in IDLE for `rx` to return high for one full bit time before accepting a new start edge.
- **Undefined:**
  - `break_det` is tied 0.
  - An all-zero frame is pushed as 0x00 with `frame_err` set.
  - Normal edge detection resumes immediately.

## Test plan
- **Basic reception:** defaults, send "Hello World!\n" back-to-back at 115200. Expect 13 bytes in the FIFO, `fifo_count` = 13, popped in order (0x48 first, 0x0A last), no error flags.
- **Glitch rejection:** drive a 2-µs low pulse on idle `rx`. Expect the FSM back in IDLE, `fifo_count` = 0, no flags.
- **Parity:** `PARITY` = 2, `DATA_BITS` = 7. Send 0x41 with correct parity, then 0x41 with the parity bit flipped. Expect both bytes in the FIFO, with `parity_err` set only after the second frame; `err_clr` pulse then clears it.
- **Frame error:** send 0x55 with the stop bit held low. Expect 0x55 pushed and `frame_err` = 1.
- **Overrun and wrap:** `FIFO_DEPTH` = 4. Send 0x01..0x05 with no reads. Expect `fifo_count` = 4, `overrun_err` = 1, reads return 0x01..0x04. Then send 0x06..0x09 to exercise pointer wrap, and assert `rd_en` on the exact push cycle while full: no overrun.
- **Reset mid-frame, and break:** assert `rst_n` low during DATA bit 3. Expect all outputs at reset values, and a following 0x5A received correctly. With `UART_RX_BREAK_DETECT_EN` defined, hold `rx` low for 20 bit times: expect `break_det` = 1, `frame_err` = 1, `fifo_count` unchanged.
